score_keeper: RTL

- Produces the 4-digit BCD `score` consumed by the input/command controller, which derives gravity speed from it; also produces line, level, combo and high-score values for the display.
- Consumes line-clear events from the playfield engine, scaled by a per-event point table plus a combo bonus.
- Applies points to the BCD score one count per cycle through a pending accumulator, so arithmetic stays simple.
- Clears the session on each new game and latches the high score at game over.

---
 rtl/score_keeper.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Score/line/level/combo bookkeeping for the playfield. Points queue into a
// binary pending accumulator and drain into the BCD score one count per cycle.
module score_keeper #(
  parameter int PEND_W          = 8,
  parameter int MAX_COMBO       = 9,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        over,
  input  logic        clear_valid,
  input  logic [2:0]  clear_lines,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [7:0]  lines_bcd,
  output logic [3:0]  level,
  output logic [3:0]  combo,
  output logic        busy
);
  localparam int SW = PEND_W + 1;

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN_OVER, LATCHED} state_t;

  state_t              state_q, state_d;
  logic                prev_start_q;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [15:0]         score_q, score_d, hs_q, hs_d;
  logic [6:0]          lines_q, lines_d;
  logic [3:0]          combo_q, combo_d;

  logic                sess_clr, accept, pend_nz, hs_load;
  logic [2:0]          n;
  logic [3:0]          base;
  logic [4:0]          pts;
  logic [SW-1:0]       pend_sum;
  logic [7:0]          lines_sum;
  logic [6:0]          lvl_raw;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Datapath next state
  always_comb begin
    sess_clr = start & ~prev_start_q;
    accept   = clear_valid & start & ~over & ~sess_clr;
    pend_nz  = (pend_q != '0);
    n        = (clear_lines > 3'd4) ? 3'd4 : clear_lines;
    case (n)
      3'd1:    base = 4'd1;
      3'd2:    base = 4'd3;
      3'd3:    base = 4'd5;
      3'd4:    base = 4'd8;
      default: base = 4'd0;
    endcase
    pts = (accept && n != 3'd0) ? ({1'b0, base} + {1'b0, combo_q}) : 5'd0;

    // Drain and new points land in the same cycle; clamp instead of wrapping
    pend_sum = {1'b0, pend_q} - SW'(pend_nz) + SW'(pts);
    pend_d   = pend_sum[PEND_W] ? '1 : pend_sum[PEND_W-1:0];

    score_d = (pend_nz && score_q != 16'h9999) ? bcd_inc(score_q) : score_q;

    lines_sum = {1'b0, lines_q} + {5'd0, n};
    combo_d   = combo_q;
    lines_d   = lines_q;
    if (accept) begin
      if (n == 3'd0) combo_d = 4'd0;
      else begin
        combo_d = (combo_q >= 4'(MAX_COMBO)) ? 4'(MAX_COMBO) : combo_q + 4'd1;
        lines_d = (lines_sum > 8'd99) ? 7'd99 : lines_sum[6:0];
      end
    end

    if (sess_clr) begin
      pend_d  = '0;
      score_d = '0;
      lines_d = '0;
      combo_d = '0;
    end
  end

  // Session FSM; high score is compared once the over episode has drained
  always_comb begin
    state_d = state_q;
    hs_load = 1'b0;
    if (sess_clr) state_d = PLAY;
    else begin
      case (state_q)
        PLAY: begin
          if (!start) state_d = IDLE;
          else if (over) begin
            if (!pend_nz) begin
              hs_load = 1'b1;
              state_d = LATCHED;
            end else state_d = DRAIN_OVER;
          end
        end
        DRAIN_OVER: begin
          if (!pend_nz) begin
            hs_load = 1'b1;
            state_d = LATCHED;
          end
        end
        default: state_d = state_q;
      endcase
    end
    hs_d = (hs_load && score_q > hs_q) ? score_q : hs_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prev_start_q <= 1'b0;
      pend_q       <= '0;
      score_q      <= '0;
      hs_q         <= '0;
      lines_q      <= '0;
      combo_q      <= '0;
    end else begin
      state_q      <= state_d;
      prev_start_q <= start;
      pend_q       <= pend_d;
      score_q      <= score_d;
      hs_q         <= hs_d;
      lines_q      <= lines_d;
      combo_q      <= combo_d;
    end
  end

  always_comb begin
    lvl_raw    = lines_q / 7'(LINES_PER_LEVEL);
    level      = (lvl_raw > 7'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : 4'(lvl_raw);
    lines_bcd  = {4'(lines_q / 7'd10), 4'(lines_q % 7'd10)};
    score      = score_q;
    high_score = hs_q;
    combo      = combo_q;
    busy       = pend_nz;
  end
endmodule
